// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - req/ack data memory bus between the memory stage and data memory
interface mem_stage_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic [1:0]        bus_be;
   logic              bus_we;
   logic              bus_req;
   logic              bus_ack;
   logic [DATA_W-1:0] bus_rdata;

   modport master (
      output bus_addr, bus_wdata, bus_be, bus_we, bus_req,
      input  bus_ack, bus_rdata
   );

   modport slave (
      input  bus_addr, bus_wdata, bus_be, bus_we, bus_req,
      output bus_ack, bus_rdata
   );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - CPU memory-access stage: byte/word loads and stores over a req/ack bus,
// odd-address words split into two little-endian byte transactions.
module mem_stage #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [15:0]       pc_in,
   input  logic [31:0]       control_signals_in,
   input  logic [15:0]       imm_in,
   input  logic [ADDR_W-1:0] addr_in,
   output logic [2:0]        rf_regC,
   input  logic [DATA_W-1:0] rf_dataC,
   mem_stage_if.master       bus,
   output logic              stall,
   output logic              valid_out,
   output logic [DATA_W-1:0] result_out,
   output logic [31:0]       control_signals_out,
   output logic [15:0]       imm_out,
   output logic [15:0]       pc_out
);
   // Control word layout: memory op bits [3:0], register select [6:4]
   localparam int RD_B   = 0;
   localparam int RD_W   = 1;
   localparam int WR_B   = 2;
   localparam int WR_W   = 3;
   localparam int REG_LO = 4;

   typedef enum logic [1:0] {IDLE, ACC1, ACC2} state_t;

   state_t            state_q, state_d;
   logic [31:0]       ctrl_q, ctrl_d;
   logic [15:0]       imm_q, imm_d, pc_q, pc_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [7:0]        lo_q, lo_d;
   logic              req_q, req_d, we_q, we_d, valid_q, valid_d;
   logic [1:0]        be_q, be_d;
   logic [ADDR_W-1:0] baddr_q, baddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d, result_q, result_d;
   logic [31:0]       ctrl_out_q, ctrl_out_d;
   logic [15:0]       imm_out_q, imm_out_d, pc_out_q, pc_out_d;

   logic              in_mem, in_write, in_word, cur_write, cur_word, done;
   logic [DATA_W-1:0] rd_val;

   // Writes beat reads, word beats byte
   assign in_write  = control_signals_in[WR_B] | control_signals_in[WR_W];
   assign in_word   = in_write ? control_signals_in[WR_W] : control_signals_in[RD_W];
   assign in_mem    = in_write | control_signals_in[RD_B] | control_signals_in[RD_W];
   assign cur_write = ctrl_q[WR_B] | ctrl_q[WR_W];
   assign cur_word  = cur_write ? ctrl_q[WR_W] : ctrl_q[RD_W];

   always_comb begin
      state_d    = state_q;
      ctrl_d     = ctrl_q;
      imm_d      = imm_q;
      pc_d       = pc_q;
      addr_d     = addr_q;
      data_d     = data_q;
      lo_d       = lo_q;
      req_d      = req_q;
      we_d       = we_q;
      be_d       = be_q;
      baddr_d    = baddr_q;
      wdata_d    = wdata_q;
      valid_d    = 1'b0;
      result_d   = result_q;
      ctrl_out_d = ctrl_out_q;
      imm_out_d  = imm_out_q;
      pc_out_d   = pc_out_q;
      done       = 1'b0;
      rd_val     = '0;
      case (state_q)
         IDLE: begin
            if (en && !in_mem) begin
               valid_d    = 1'b1;
               result_d   = addr_in;
               ctrl_out_d = control_signals_in;
               imm_out_d  = imm_in;
               pc_out_d   = pc_in;
            end else if (en) begin
               ctrl_d  = control_signals_in;
               imm_d   = imm_in;
               pc_d    = pc_in;
               addr_d  = addr_in;
               data_d  = rf_dataC;
               state_d = ACC1;
               req_d   = 1'b1;
               we_d    = in_write;
               baddr_d = {addr_in[ADDR_W-1:1], 1'b0};
               if (in_word && !addr_in[0]) begin
                  be_d    = 2'b11;
                  wdata_d = rf_dataC;
               end else begin
                  // Byte access, or the low byte of an odd word, which sits in the high lane
                  be_d    = addr_in[0] ? 2'b10 : 2'b01;
                  wdata_d = {rf_dataC[7:0], rf_dataC[7:0]};
               end
            end
         end
         ACC1: begin
            if (bus.bus_ack) begin
               if (cur_word && addr_q[0]) begin
                  state_d = ACC2;
                  lo_d    = bus.bus_rdata[15:8];
                  baddr_d = addr_q + ADDR_W'(1);
                  be_d    = 2'b01;
                  wdata_d = {data_q[15:8], data_q[15:8]};
               end else begin
                  done   = 1'b1;
                  rd_val = cur_word ? bus.bus_rdata
                         : {8'h00, addr_q[0] ? bus.bus_rdata[15:8] : bus.bus_rdata[7:0]};
               end
            end
         end
         ACC2: begin
            if (bus.bus_ack) begin
               done   = 1'b1;
               rd_val = {bus.bus_rdata[7:0], lo_q};
            end
         end
         default: state_d = IDLE;
      endcase
      if (done) begin
         state_d    = IDLE;
         req_d      = 1'b0;
         valid_d    = 1'b1;
         result_d   = cur_write ? addr_q : rd_val;
         ctrl_out_d = ctrl_q;
         imm_out_d  = imm_q;
         pc_out_d   = pc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         ctrl_q     <= '0;
         imm_q      <= '0;
         pc_q       <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         lo_q       <= '0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         be_q       <= '0;
         baddr_q    <= '0;
         wdata_q    <= '0;
         valid_q    <= 1'b0;
         result_q   <= '0;
         ctrl_out_q <= '0;
         imm_out_q  <= '0;
         pc_out_q   <= '0;
      end else begin
         state_q    <= state_d;
         ctrl_q     <= ctrl_d;
         imm_q      <= imm_d;
         pc_q       <= pc_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         lo_q       <= lo_d;
         req_q      <= req_d;
         we_q       <= we_d;
         be_q       <= be_d;
         baddr_q    <= baddr_d;
         wdata_q    <= wdata_d;
         valid_q    <= valid_d;
         result_q   <= result_d;
         ctrl_out_q <= ctrl_out_d;
         imm_out_q  <= imm_out_d;
         pc_out_q   <= pc_out_d;
      end
   end

   assign rf_regC             = (state_q == IDLE) ? control_signals_in[REG_LO +: 3] : ctrl_q[REG_LO +: 3];
   assign stall               = (state_q != IDLE);
   assign bus.bus_addr        = baddr_q;
   assign bus.bus_wdata       = wdata_q;
   assign bus.bus_be          = be_q;
   assign bus.bus_we          = we_q;
   assign bus.bus_req         = req_q;
   assign valid_out           = valid_q;
   assign result_out          = result_q;
   assign control_signals_out = ctrl_out_q;
   assign imm_out             = imm_out_q;
   assign pc_out              = pc_out_q;
endmodule
